divide_by_n_fsm: RTL

Runtime-programmable clock-rate divider FSM, the parametrised successor of the fixed divide-by-3 state machine. It produces a one-cycle pulse or a near-50% square wave every N clock cycles, with N loadable at run time. Divisor changes are glitch-free because a new value only takes effect at a period boundary. It sits beside the other small sequential utility blocks and drives clock-enable or tick inputs of downstream logic.

---
 rtl/divider_pkg.sv | 12 +
 rtl/mod_n_counter.sv | 26 ++
 rtl/divide_by_n_fsm.sv | 115 +++++++++++
 3 files changed

// File: rtl/divider_pkg.sv
// Shared types and constants for the runtime-programmable clock-rate divider.
package divider_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } div_state_t;

  localparam logic MODE_PULSE  = 1'b0;
  localparam logic MODE_SQUARE = 1'b1;

endpackage

// File: rtl/mod_n_counter.sv
// WIDTH-bit modulo counter: counts 0..limit and wraps, with synchronous clear.
module mod_n_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             at_max
);

  assign at_max = (count == limit);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= at_max ? '0 : count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/divide_by_n_fsm.sv
// Programmable divide-by-N: pulse or square output every N cycles; new divisors
// take effect only at a period boundary so the output never glitches.
module divide_by_n_fsm
  import divider_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DEFAULT_DIV = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] div_in,
  output logic             y,
  output logic             wrap,
  output logic [WIDTH-1:0] div_cur
);

  localparam int unsigned WP1 = WIDTH + 1;

  div_state_t       state;
  div_state_t       state_nxt;
  logic             run;
  logic             cnt_clr;
  logic             cnt_inc;
  logic             at_max;
  logic             apply;
  logic             pending;
  logic [WIDTH-1:0] div_pend;
  logic [WIDTH-1:0] div_eff;
  logic [WIDTH-1:0] limit;
  logic [WIDTH-1:0] count;
  logic [WP1-1:0]   hi;

  // A requested divisor of 0 behaves as divide-by-1.
  function automatic logic [WIDTH-1:0] nonzero(input logic [WIDTH-1:0] d);
    return (d == '0) ? WIDTH'(1) : d;
  endfunction

  assign div_eff = nonzero(div_cur);
  assign limit   = div_eff - WIDTH'(1);
  assign hi      = WP1'(({1'b0, div_eff} + WP1'(1)) >> 1);

  mod_n_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk    (clk),
    .reset  (reset),
    .clr    (cnt_clr),
    .inc    (cnt_inc),
    .limit  (limit),
    .count  (count),
    .at_max (at_max)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    case (state)
      IDLE: begin
        cnt_clr = 1'b1;
        if (en) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (!en) begin
          state_nxt = IDLE;
          cnt_clr   = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_clr   = 1'b1;
      end
    endcase
  end

  assign run  = (state == RUN);
  assign wrap = run && at_max;
  assign y    = run && ((mode == MODE_SQUARE) ? ({1'b0, count} < hi) : (count == '0));

  // Divisor shadow: loads park in div_pend until idle or the last cycle of a period.
  assign apply = (state == IDLE) || wrap;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cur  <= WIDTH'(DEFAULT_DIV);
      div_pend <= '0;
      pending  <= 1'b0;
    end else if (apply) begin
      if (load) begin
        div_cur <= nonzero(div_in);
        pending <= 1'b0;
      end else if (pending) begin
        div_cur <= nonzero(div_pend);
        pending <= 1'b0;
      end
    end else if (load) begin
      div_pend <= div_in;
      pending  <= 1'b1;
    end
  end

endmodule
